// File: rtl/pipe_skid_reg_pkg.sv
// pipe_skid_reg_pkg
//   Shared CPU pipeline definitions: per-stage payload bundles that travel
//   through pipe_skid_reg instances (ID/EXE, EXE/MEM, MEM/WB), the payload
//   widths derived from those bundles, and the skid-buffer state encoding.
//   No ports; import with "import pipe_skid_reg_pkg::*;".
package pipe_skid_reg_pkg;

   // Holding-register state: number of entries currently held.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      MAIN  = 2'd1,
      FULL  = 2'd2
   } skid_state_t;

   typedef struct packed {
      logic       en;
      logic [2:0] size;
      logic       sign_ext;
   } LoadType;

   typedef struct packed {
      logic       en;
      logic [1:0] size;
   } StoreType;

   typedef struct packed {
      logic       en;
      logic [4:0] addr;
   } RegsWrType;

   typedef struct packed {
      logic        valid;
      logic [4:0]  code;
      logic [31:0] epc;
   } ExceptinPipeType;

   typedef struct packed {
      logic [31:0]     pc;
      logic [31:0]     alu_a;
      logic [31:0]     alu_b;
      logic [31:0]     store_val;
      LoadType         load;
      StoreType        store;
      RegsWrType       regs_wr;
      ExceptinPipeType excp;
   } id_exe_payload_t;

   typedef struct packed {
      logic [31:0]     pc;
      logic [31:0]     alu_result;
      logic [31:0]     store_val;
      LoadType         load;
      StoreType        store;
      RegsWrType       regs_wr;
      ExceptinPipeType excp;
   } exe_mem_payload_t;

   typedef struct packed {
      logic [31:0]     pc;
      logic [31:0]     wb_data;
      RegsWrType       regs_wr;
      ExceptinPipeType excp;
   } mem_wb_payload_t;

   // DATA_W to use for each stage register instance.
   localparam int unsigned ID_EXE_DATA_W  = $bits(id_exe_payload_t);
   localparam int unsigned EXE_MEM_DATA_W = $bits(exe_mem_payload_t);
   localparam int unsigned MEM_WB_DATA_W  = $bits(mem_wb_payload_t);

   function automatic logic [1:0] state_occupancy(input skid_state_t s);
      logic [1:0] occ;
      case (s)
         MAIN:    occ = 2'd1;
         FULL:    occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if
//   Valid/ready handshake bundle around one pipeline stage register.
//   Upstream side : in_valid, in_ready, in_data
//   Downstream    : out_valid, out_ready, out_data
//   Status        : occupancy (entries held, 0..2)
//   master : the environment driving the stage (source + sink)
//   slave  : the stage register itself
interface pipe_skid_reg_if #(
   parameter int unsigned DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, occupancy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, occupancy
   );
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
//   Pipeline stage register with valid/ready handshake. SKID_EN=1 gives a
//   two-entry skid buffer whose in_ready is registered (no combinational
//   path from out_ready); SKID_EN=0 gives a single register whose in_ready
//   is combinational (!out_valid || out_ready).
//   Ports:
//     clk   - clock, rising edge
//     rst   - asynchronous active-high reset
//     flush - synchronous squash of all held entries (beats any transfer)
//     bus   - pipe_skid_reg_if.slave handshake bundle
module pipe_skid_reg
   import pipe_skid_reg_pkg::*;
#(
   parameter int unsigned       DATA_W   = 32,
   parameter bit                SKID_EN  = 1'b1,
   parameter logic [DATA_W-1:0] RST_DATA = '0
) (
   input logic            clk,
   input logic            rst,
   input logic            flush,
   pipe_skid_reg_if.slave bus
);

   skid_state_t       state;
   skid_state_t       state_nxt;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] skid_q;
   logic              in_ready;
   logic              out_valid;
   logic [1:0]        occupancy;
   logic              in_xfer;
   logic              out_xfer;

   assign in_xfer  = bus.in_valid && in_ready;
   assign out_xfer = out_valid && bus.out_ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   // Next-state logic; FULL is unreachable when SKID_EN=0 because in_ready
   // then implies an output transfer whenever something is held.
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         unique case (state)
            EMPTY: if (in_xfer) state_nxt = MAIN;
            MAIN: begin
               if (in_xfer && !out_xfer && SKID_EN) state_nxt = FULL;
               else if (!in_xfer && out_xfer)       state_nxt = EMPTY;
            end
            FULL:    if (out_xfer) state_nxt = MAIN;
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // Output logic
   always_comb begin
      out_valid = (state != EMPTY);
      occupancy = state_occupancy(state);
   end

   // Main register: always the head of the stream. It keeps its last value
   // while EMPTY so out_data never goes unknown.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q <= RST_DATA;
      end else if (flush) begin
         main_q <= RST_DATA;
      end else if (state == FULL) begin
         if (out_xfer) main_q <= skid_q;
      end else if (in_xfer && (state == EMPTY || out_xfer)) begin
         main_q <= in_data_w();
      end
   end

   function automatic logic [DATA_W-1:0] in_data_w();
      return bus.in_data;
   endfunction

   generate
      if (SKID_EN) begin : g_skid
         logic ready_q;

         // Skid register catches the word accepted while the head stalls.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               skid_q <= RST_DATA;
            end else if (flush) begin
               skid_q <= RST_DATA;
            end else if (state == MAIN && in_xfer && !out_xfer) begin
               skid_q <= bus.in_data;
            end
         end

         // Registered copy of (state != FULL), computed from the next state.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) ready_q <= 1'b1;
            else     ready_q <= (state_nxt != FULL);
         end

         assign in_ready = ready_q;
      end else begin : g_single
         assign skid_q   = RST_DATA;
         assign in_ready = !out_valid || bus.out_ready;
      end
   endgenerate

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = main_q;
   assign bus.occupancy = occupancy;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg
//   Drives one SKID_EN=1 and one SKID_EN=0 instance with the same stimulus
//   and checks both every cycle against a queue-based model of the stage.
module tb_pipe_skid_reg;

   localparam logic [31:0] RST = 32'hC0DE_0001;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   int checks;
   int errors;

   // Model: held payloads in order, plus the last payload that left
   // (what out_data shows while nothing is held).
   logic [31:0] q1[$];
   logic [31:0] q0[$];
   logic [31:0] held1;
   logic [31:0] held0;

   pipe_skid_reg_if #(.DATA_W(32)) if1 ();
   pipe_skid_reg_if #(.DATA_W(32)) if0 ();

   assign if1.in_valid  = in_valid;
   assign if1.in_data   = in_data;
   assign if1.out_ready = out_ready;
   assign if0.in_valid  = in_valid;
   assign if0.in_data   = in_data;
   assign if0.out_ready = out_ready;

   pipe_skid_reg #(.DATA_W(32), .SKID_EN(1'b1), .RST_DATA(RST)) dut1 (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (if1)
   );

   pipe_skid_reg #(.DATA_W(32), .SKID_EN(1'b0), .RST_DATA(RST)) dut0 (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (if0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_ready1();
      return q1.size() != 2;
   endfunction

   function automatic logic exp_ready0();
      return (q0.size() == 0) || out_ready;
   endfunction

   task automatic model_reset();
      q1.delete();
      q0.delete();
      held1 = RST;
      held0 = RST;
   endtask

   // Applies one clock edge worth of transfers using pre-edge inputs.
   task automatic model_edge();
      logic ix1, ix0, ox1, ox0;
      if (rst || flush) begin
         model_reset();
      end else begin
         ix1 = in_valid && exp_ready1();
         ix0 = in_valid && exp_ready0();
         ox1 = (q1.size() > 0) && out_ready;
         ox0 = (q0.size() > 0) && out_ready;
         if (ox1) held1 = q1.pop_front();
         if (ox0) held0 = q0.pop_front();
         if (ix1) q1.push_back(in_data);
         if (ix0) q0.push_back(in_data);
      end
   endtask

   task automatic compare_all();
      cmp("s1_out_valid", if1.out_valid, q1.size() > 0);
      cmp("s1_out_data",  if1.out_data,  (q1.size() > 0) ? q1[0] : held1);
      cmp("s1_occupancy", if1.occupancy, q1.size());
      cmp("s1_in_ready",  if1.in_ready,  exp_ready1());
      cmp("s0_out_valid", if0.out_valid, q0.size() > 0);
      cmp("s0_out_data",  if0.out_data,  (q0.size() > 0) ? q0[0] : held0);
      cmp("s0_occupancy", if0.occupancy, q0.size());
      cmp("s0_in_ready",  if0.in_ready,  exp_ready0());
   endtask

   // One cycle: inputs are already set; check at negedge, advance at posedge,
   // return 1 time unit after the edge so new inputs stay clear of it.
   task automatic step();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle(input int n);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      flush     = 1'b0;
      repeat (n) step();
   endtask

   logic [31:0] words[100];

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      model_reset();

      // Reset state
      repeat (2) step();
      cmp("rst_s1_in_ready", if1.in_ready, 1'b1);
      cmp("rst_s0_in_ready", if0.in_ready, 1'b1);
      cmp("rst_s1_out_data", if1.out_data, 32'hC0DE_0001);
      cmp("rst_s1_occ",      if1.occupancy, 2'd0);
      rst = 1'b0;

      // Fill and drain
      in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b0;
      step();
      cmp("fill_occ1", if1.occupancy, 2'd1);
      in_data = 32'h22;
      step();
      cmp("fill_occ2",      if1.occupancy, 2'd2);
      cmp("fill_in_ready",  if1.in_ready,  1'b0);
      cmp("fill_out_data",  if1.out_data,  32'h11);
      // in_ready must not follow out_ready combinationally in skid mode
      out_ready = 1'b1; in_valid = 1'b0;
      #1;
      cmp("skid_ready_comb", if1.in_ready, 1'b0);
      cmp("drain_first",     if1.out_data, 32'h11);
      step();
      cmp("drain_second", if1.out_data, 32'h22);
      step();
      cmp("drain_empty_valid", if1.out_valid, 1'b0);
      cmp("drain_empty_hold",  if1.out_data,  32'h22);
      idle(2);

      // Streaming at full rate with 1-cycle latency
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         words[i] = $urandom;
         in_data  = words[i];
         step();
         cmp("stream_s1_data",  if1.out_data,  words[i]);
         cmp("stream_s1_valid", if1.out_valid, 1'b1);
         cmp("stream_s0_data",  if0.out_data,  words[i]);
      end
      idle(3);

      // Flush while FULL beats a simultaneous input and output transfer
      in_valid = 1'b1; out_ready = 1'b0;
      in_data = 32'h44; step();
      in_data = 32'h55; step();
      cmp("pre_flush_occ", if1.occupancy, 2'd2);
      flush = 1'b1; in_data = 32'h33; out_ready = 1'b1;
      step();
      cmp("flush_valid", if1.out_valid, 1'b0);
      cmp("flush_data",  if1.out_data,  32'hC0DE_0001);
      cmp("flush_occ",   if1.occupancy, 2'd0);
      flush = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         cmp("flush_no_33", (if1.out_valid && if1.out_data == 32'h33), 1'b0);
      end

      // Asynchronous reset between edges while FULL
      in_valid = 1'b1; out_ready = 1'b0;
      in_data = 32'h61; step();
      in_data = 32'h62; step();
      cmp("pre_rst_occ", if1.occupancy, 2'd2);
      #1 rst = 1'b1;
      #1;
      cmp("arst_s1_valid", if1.out_valid, 1'b0);
      cmp("arst_s1_occ",   if1.occupancy, 2'd0);
      cmp("arst_s1_data",  if1.out_data,  32'hC0DE_0001);
      cmp("arst_s0_valid", if0.out_valid, 1'b0);
      model_reset();
      #1 rst = 1'b0;
      in_valid = 1'b0;
      step();

      // Single-register stall
      in_valid = 1'b1; in_data = 32'hAB; out_ready = 1'b0;
      step();
      in_data = 32'hCD;
      #1;
      cmp("stall_s0_ready", if0.in_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         cmp("stall_s0_data",  if0.out_data, 32'hAB);
         cmp("stall_s0_ready", if0.in_ready, 1'b0);
      end
      out_ready = 1'b1;
      #1;
      cmp("release_s0_ready", if0.in_ready, 1'b1);
      step();
      cmp("release_s0_data", if0.out_data, 32'hCD);
      idle(3);

      // Random backpressure with occasional flush
      for (int i = 0; i < 10000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = $urandom;
         out_ready = 1'($urandom_range(0, 1));
         flush     = ($urandom_range(0, 99) == 0);
         step();
      end
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of the payload carried between pipeline stages (ID->EXE, EXE->MEM, MEM->WB payload bundles).
REQ-002 Parameter SKID_EN, default 1: 1 selects the two-entry skid mode; 0 selects the single-register mode with a combinational ready path.
REQ-003 Parameter RST_DATA, default 0: DATA_W-bit value loaded into all data registers on reset or flush.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port flush, input, 1: synchronous squash of all held entries, e.g. on an exception or a branch.
REQ-007 Port in_valid, input, 1: the upstream stage presents a payload.
REQ-008 Port in_ready, output, 1: this stage accepts a payload this cycle.
REQ-009 Port in_data, input, DATA_W: upstream payload.
REQ-010 Port out_valid, output, 1: a payload is presented downstream.
REQ-011 Port out_ready, input, 1: the downstream stage accepts a payload this cycle.
REQ-012 Port out_data, output, DATA_W: downstream payload.
REQ-013 Port occupancy, output, 2: number of held entries (0 to 2; the value is never 2 when SKID_EN=0).

Function
REQ-014 A transfer occurs on an input or output side when valid && ready are both high at a rising clk edge.
REQ-015 Payload order is preserved, and no accepted payload is dropped or duplicated unless a flush occurs.
REQ-016 With SKID_EN=1, the state machine has three states: EMPTY, MAIN (one entry held), and FULL (main entry plus skid entry).
REQ-017 out_valid is 1 exactly when the state is MAIN or FULL, and out_data always equals the main register.
REQ-018 With SKID_EN=1, in_ready is registered, equals (state != FULL), and has no combinational path from out_ready.
REQ-019 The SKID_EN=1 transitions are:
- EMPTY with an input transfer goes to MAIN.
- MAIN with an input transfer and no output transfer goes to FULL, and the input is captured into the skid register.
- MAIN with an input transfer and an output transfer stays in MAIN, and the main register is loaded from in_data.
- MAIN with an output transfer only goes to EMPTY.
- FULL with an output transfer goes to MAIN, and the main register is loaded from the skid register.
- In all other cases the state is held.
REQ-020 With SKID_EN=0, the skid register does not exist and in_ready = !out_valid || out_ready (combinational).
REQ-021 With SKID_EN=0, an input transfer loads the main register and sets out_valid; an output transfer with no input transfer clears out_valid.
REQ-022 Latency from input transfer to out_valid is exactly 1 cycle when the stage is empty or draining.
REQ-023 Throughput is 1 transfer per cycle when out_ready is held high, in both modes.
REQ-024 Flush has priority over every transfer in the same cycle: the next state is EMPTY, both data registers are set to RST_DATA, and any in_valid presented that cycle is discarded.
REQ-025 When the state is EMPTY, out_data is held, not 'x'.
REQ-026 The payload is treated as opaque; no field interpretation is performed.
REQ-027 occupancy equals 0, 1 or 2 for EMPTY, MAIN or FULL respectively.

Reset
REQ-028 While rst=1, asynchronously:
- state = EMPTY, out_valid = 0, occupancy = 0
- out_data = RST_DATA, and the skid register = RST_DATA
- in_ready = 1 when SKID_EN=1 (registered); when SKID_EN=0 it follows REQ-020, giving 1
REQ-029 Reset asserted mid-operation discards all held entries immediately, without waiting for a clock edge.
REQ-030 The first transfer may occur at the first rising clk edge after rst deasserts.

Structure
REQ-031 Stage payload typedefs belong in the shared CPU defines package, together with a DATA_W derived via $bits of each bundle:
- LoadType, StoreType, RegsWrType, ExceptinPipeType
- the per-stage packed payload structs
REQ-032 The state enum (EMPTY/MAIN/FULL) belongs in the same package.
REQ-033 There are no sub-modules; ID/EXE, EXE/MEM and MEM/WB are each one instance of pipe_skid_reg, with the bundle packed onto in_data.

Verification
REQ-034 Fill/drain (SKID_EN=1, DATA_W=32): after reset, in_valid=1 with data 0x11, then 0x22, with out_ready=0 -> occupancy 1 then 2, in_ready=0, out_data=0x11; then out_ready=1 -> outputs 0x11 then 0x22, then EMPTY.
REQ-035 Streaming: 100 random words, out_ready=1 -> one output per cycle with 1-cycle latency, and order is matched by the scoreboard.
REQ-036 Random backpressure (both modes): in_valid and out_ready each at 50% for 10k cycles -> no loss, duplication or reorder, and no combinational in_ready dependence on out_ready when SKID_EN=1.
REQ-037 Flush in FULL, with a simultaneous in_valid=1 (data 0x33) and out_ready=1 -> the next cycle is EMPTY, out_valid=0, out_data=RST_DATA, and 0x33 never appears.
REQ-038 Async reset: rst pulsed between edges while FULL -> out_valid=0 and occupancy=0 before the next clk edge.
REQ-039 SKID_EN=0 stall: MAIN holding 0xAB with out_ready=0 -> in_ready=0, and out_data stays 0xAB until out_ready=1.
